// File: rtl/hc595_stream_if.sv
// Handshake bundle between two requesters (A and B) and the 74HC595 stream
// controller. Each requester presents valid/data and receives ready.
interface hc595_stream_if #(
  parameter int NBITS = 8
);
  logic             a_valid;
  logic             a_ready;
  logic [NBITS-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [NBITS-1:0] b_data;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/hc595_stream_ctrl.sv
// Serial stream controller for a 74HC595-style shift register.
// Accepts a word from requester A (or B), shifts it out MSB first on
// ser_o/srck_o, then pulses rck_o to latch it. Every srck/rck half-phase
// lasts DIV clk cycles, so one transfer takes 2*DIV*(NBITS+1) cycles.
// g_o keeps the target outputs disabled until the first word is latched.
// Optional build macro HC595_STREAM_ARB_EN: when defined, both requesters
// are served with round-robin arbitration; otherwise only A is served.
module hc595_stream_ctrl #(
  parameter int NBITS = 8,
  parameter int DIV   = 2
) (
  input  logic         clk,
  input  logic         sclrn,
  hc595_stream_if.slave bus,
  output logic         ser_o,
  output logic         srck_o,
  output logic         rck_o,
  output logic         g_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_HI,
    SHIFT_LO,
    LATCH_HI,
    LATCH_LO
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [NBITS-1:0] sh_next;
  logic [NBITS-1:0] grant_data;
  logic             ser_q, ser_d;
  logic             srck_q, srck_d;
  logic             rck_q, rck_d;
  logic             g_q, g_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             idle;
  logic             req;
  logic             accept;
  logic             cnt_last;

  assign idle        = (state_q == IDLE);
  assign bus.a_ready = idle;
  assign accept      = idle && req;
  assign cnt_last    = (cnt_q == CNT_LAST);
  assign sh_next     = sh_q << 1;

`ifdef HC595_STREAM_ARB_EN
  // Round-robin pointer: 0 favours A, 1 favours B; flips only on a contested grant.
  logic ptr_q, ptr_d;
  logic grant_b;

  assign bus.b_ready = idle;
  assign req         = bus.a_valid || bus.b_valid;
  assign grant_b     = bus.b_valid && (!bus.a_valid || ptr_q);
  assign grant_data  = grant_b ? bus.b_data : bus.a_data;

  // Advance the pointer past the port that won a contested request.
  always_comb begin
    ptr_d = ptr_q;
    if (idle && bus.a_valid && bus.b_valid) begin
      ptr_d = ~ptr_q;
    end
  end

  // Pointer register, back to A on reset.
  always_ff @(posedge clk or negedge sclrn) begin
    if (!sclrn) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  assign bus.b_ready = 1'b0;
  assign req         = bus.a_valid;
  assign grant_data  = bus.a_data;
`endif

  // Next-state and registered-output logic for the transfer sequencer.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    ser_d   = ser_q;
    g_d     = g_q;
    if (done_q) g_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT_HI;
          cnt_d   = '0;
          bits_d  = BIT_LAST;
          sh_d    = grant_data;
          ser_d   = grant_data[NBITS-1];
        end
      end
      SHIFT_HI: begin
        if (cnt_last) begin
          state_d = SHIFT_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT_LO: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bits_q == '0) begin
            state_d = LATCH_HI;
          end else begin
            state_d = SHIFT_HI;
            bits_d  = bits_q - BW'(1);
            sh_d    = sh_next;
            ser_d   = sh_next[NBITS-1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH_HI: begin
        if (cnt_last) begin
          state_d = LATCH_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH_LO: begin
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    srck_d = (state_d == SHIFT_HI);
    rck_d  = (state_d == LATCH_HI);
    busy_d = (state_d != IDLE);
    done_d = (state_d == LATCH_LO) && (cnt_d == CNT_LAST);
  end

  // State and output registers; reset parks the target safely with outputs disabled.
  always_ff @(posedge clk or negedge sclrn) begin
    if (!sclrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      ser_q   <= 1'b0;
      srck_q  <= 1'b0;
      rck_q   <= 1'b0;
      g_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      ser_q   <= ser_d;
      srck_q  <= srck_d;
      rck_q   <= rck_d;
      g_q     <= g_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ser_o  = ser_q;
  assign srck_o = srck_q;
  assign rck_o  = rck_q;
  assign g_o    = g_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_hc595_stream_ctrl.sv
// Self-checking bench for hc595_stream_ctrl. A cycle-level reference model
// predicts srck/rck/busy/done/g/ready timing; a scoreboard queue holds the
// word granted at each acceptance and is compared against the word
// reassembled from ser_o when the transfer completes.
module tb_hc595_stream_ctrl;

  localparam int NBITS = 8;
  localparam int DIV   = 2;
  localparam int LEN   = 2 * DIV * (NBITS + 1);

  logic clk = 1'b0;
  logic sclrn;
  logic ser_o, srck_o, rck_o, g_o, busy_o, done_o;

  hc595_stream_if #(.NBITS(NBITS)) bus ();

  hc595_stream_ctrl #(.NBITS(NBITS), .DIV(DIV)) dut (
    .clk    (clk),
    .sclrn  (sclrn),
    .bus    (bus),
    .ser_o  (ser_o),
    .srck_o (srck_o),
    .rck_o  (rck_o),
    .g_o    (g_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int               cyc = 0;
  int               acc_cyc = 0;
  int               n_acc = 0;
  int               n_done = 0;
  bit               in_xfer = 1'b0;
  bit               g_exp = 1'b1;
  bit               ptr_m = 1'b0;
  logic [NBITS-1:0] word = '0;
  logic [NBITS-1:0] exp_q[$];
  logic [NBITS-1:0] rx_log[$];

  always @(posedge clk) cyc++;

  // Monitor: predict outputs each cycle, sample ser_o, score completed words.
  always @(negedge clk) begin
    int   k;
    int   phase;
    bit   e_srck, e_rck, e_done, was_idle;
    logic [NBITS-1:0] e_word;
    if (!sclrn) begin
      in_xfer = 1'b0;
      g_exp   = 1'b1;
      ptr_m   = 1'b0;
      word    = '0;
      exp_q.delete();
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
    end else begin
      was_idle = !in_xfer;
      e_srck = 1'b0;
      e_rck  = 1'b0;
      e_done = 1'b0;
      phase  = 0;
      k      = 0;
      if (in_xfer) begin
        k      = cyc - acc_cyc;
        phase  = k / DIV;
        e_srck = (phase < 2 * NBITS) && (phase % 2 == 0);
        e_rck  = (phase == 2 * NBITS);
        e_done = (k == LEN - 1);
      end
      check("srck", 32'(srck_o), 32'(e_srck));
      check("rck", 32'(rck_o), 32'(e_rck));
      check("busy", 32'(busy_o), 32'(in_xfer));
      check("done", 32'(done_o), 32'(e_done));
      check("g", 32'(g_o), 32'(g_exp));
      check("a_ready", 32'(bus.a_ready), 32'(was_idle));
`ifdef HC595_STREAM_ARB_EN
      check("b_ready", 32'(bus.b_ready), 32'(was_idle));
`else
      check("b_ready", 32'(bus.b_ready), 32'd0);
`endif
      // First SHIFT_LO cycle of each bit: the target has just shifted ser_o in.
      if (in_xfer && phase < 2 * NBITS && phase % 2 == 1 && k % DIV == 0)
        word = {word[NBITS-2:0], ser_o};
      if (e_done) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        e_word = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check("word", 32'(word), 32'(e_word));
        rx_log.push_back(word);
        n_done++;
        g_exp   = 1'b0;
        in_xfer = 1'b0;
      end
      // Acceptance on the coming rising edge, with the model's own arbitration.
      if (was_idle) begin
        bit take;
        bit use_b;
        take  = 1'b0;
        use_b = 1'b0;
`ifdef HC595_STREAM_ARB_EN
        if (bus.a_valid && bus.b_valid) begin
          take = 1'b1; use_b = ptr_m; ptr_m = ~ptr_m;
        end else if (bus.a_valid) begin
          take = 1'b1;
        end else if (bus.b_valid) begin
          take = 1'b1; use_b = 1'b1;
        end
`else
        take = bus.a_valid;
`endif
        if (take) begin
          exp_q.push_back(use_b ? bus.b_data : bus.a_data);
          acc_cyc = cyc + 1;
          in_xfer = 1'b1;
          word    = '0;
          n_acc++;
        end
      end
    end
  end

  // Wait until the monitor sees acceptance number target, then step past the accept edge.
  task automatic wait_acc(input int target);
    int budget = 1000;
    while (n_acc < target && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check("acc_timeout", 32'(n_acc >= target), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int target);
    int budget = 1000;
    while (n_done < target && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check("done_timeout", 32'(n_done >= target), 32'd1);
  endtask

  initial begin
    int base;
    int rel_cyc;
    sclrn       = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_data  = '0;
    bus.b_data  = '0;
    #12;
    check("rst_ser", 32'(ser_o), 32'd0);
    check("rst_srck_i", 32'(srck_o), 32'd0);
    check("rst_rck_i", 32'(rck_o), 32'd0);
    check("rst_g", 32'(g_o), 32'd1);
    check("rst_a_ready", 32'(bus.a_ready), 32'd1);
    @(posedge clk); @(posedge clk); #3;
    sclrn = 1'b1;

    // Single A transfer: 0xA5 goes out 1,0,1,0,0,1,0,1; later port changes are ignored.
    bus.a_valid = 1'b1;
    bus.a_data  = 8'hA5;
    wait_acc(1);
    bus.a_valid = 1'b0;
    bus.a_data  = 8'hFF;
    wait_done(1);
    check("a5_word", 32'(rx_log[0]), 32'hA5);
    repeat (3) @(posedge clk);
    #1 check("g_after_done", 32'(g_o), 32'd0);

`ifdef HC595_STREAM_ARB_EN
    // Both valid continuously: A,B,A,B.
    base = n_done;
    bus.a_data = 8'h11; bus.b_data = 8'h22;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    wait_acc(base + 4);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    wait_done(base + 4);
    check("rr0", 32'(rx_log[base]),     32'h11);
    check("rr1", 32'(rx_log[base + 1]), 32'h22);
    check("rr2", 32'(rx_log[base + 2]), 32'h11);
    check("rr3", 32'(rx_log[base + 3]), 32'h22);

    // Only B for three transfers, then both: B,B,B then A.
    base = n_done;
    bus.b_data = 8'h33; bus.b_valid = 1'b1;
    wait_acc(base + 1);
    bus.b_data = 8'h44;
    wait_acc(base + 2);
    bus.b_data = 8'h55;
    wait_acc(base + 3);
    bus.a_data = 8'h66; bus.b_data = 8'h77; bus.a_valid = 1'b1;
    wait_acc(base + 4);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    wait_done(base + 4);
    check("bonly0", 32'(rx_log[base]),     32'h33);
    check("bonly1", 32'(rx_log[base + 1]), 32'h44);
    check("bonly2", 32'(rx_log[base + 2]), 32'h55);
    check("bonly_then_a", 32'(rx_log[base + 3]), 32'h66);
`else
    // Without arbitration B is never served, even alongside A.
    base = n_acc;
    bus.b_data = 8'h99; bus.b_valid = 1'b1;
    repeat (50) @(posedge clk);
    #1 check("no_b_accept", 32'(n_acc), 32'(base));
    check("no_b_busy", 32'(busy_o), 32'd0);
    base = n_done;
    bus.a_data = 8'h11; bus.a_valid = 1'b1;
    wait_acc(base + 2);
    bus.a_valid = 1'b0;
    wait_done(base + 2);
    check("a_only0", 32'(rx_log[base]),     32'h11);
    check("a_only1", 32'(rx_log[base + 1]), 32'h11);
    bus.b_valid = 1'b0;
`endif

    // Reset in cycle 10 of a transfer: abort, no done, g back to 1, immediate re-accept.
    base = n_done;
    bus.a_data = 8'hC3; bus.a_valid = 1'b1;
    wait_acc(n_acc + 1);
    bus.a_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 check("mid_busy", 32'(busy_o), 32'd1);
    sclrn = 1'b0;
    #1;
    check("arst_srck", 32'(srck_o), 32'd0);
    check("arst_rck", 32'(rck_o), 32'd0);
    check("arst_ser", 32'(ser_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_g", 32'(g_o), 32'd1);
    @(posedge clk); #3;
    sclrn   = 1'b1;
    rel_cyc = cyc;
    bus.a_data = 8'h5A; bus.a_valid = 1'b1;
    #1 check("rel_ready", 32'(bus.a_ready), 32'd1);
    wait_acc(n_acc + 1);
    bus.a_valid = 1'b0;
    check("acc_after_rst", 32'(acc_cyc), 32'(rel_cyc + 1));
    wait_done(base + 1);
    check("no_abort_done", 32'(n_done), 32'(base + 1));
    check("post_rst_word", 32'(rx_log[base]), 32'h5A);

`ifdef HC595_STREAM_ARB_EN
    // Pointer returns to A on reset.
    base = n_done;
    bus.a_data = 8'hE1; bus.b_data = 8'hE2;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    wait_acc(n_acc + 1);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    wait_done(base + 1);
    check("ptr_rst_a", 32'(rx_log[base]), 32'hE1);
`endif

    repeat (5) @(posedge clk);
    #1 check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
